// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver, 16x oversampling, 3-sample majority vote per bit.
// Baud table pairs with uart_byte_tx; the stop bit is judged mid-bit so back-to-back frames fit.
module uart_byte_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic [2:0] baud_set,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_error,
    output logic       rx_state
);

    // A chain shorter than two flops is not a synchroniser; clamp it.
    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned TICK_W = 9;
    localparam int unsigned SAMP_W = 4;
    localparam int unsigned BIDX_W = 3;

    // Oversample tick dividers: tick period = (DIV+1) clk = 50 MHz / (16 * baud).
    localparam logic [TICK_W-1:0] DIV_9600   = TICK_W'(324);
    localparam logic [TICK_W-1:0] DIV_19200  = TICK_W'(162);
    localparam logic [TICK_W-1:0] DIV_38400  = TICK_W'(80);
    localparam logic [TICK_W-1:0] DIV_57600  = TICK_W'(53);
    localparam logic [TICK_W-1:0] DIV_115200 = TICK_W'(26);

    localparam logic [SAMP_W-1:0] SAMP_FIRST  = SAMP_W'(7);
    localparam logic [SAMP_W-1:0] SAMP_SECOND = SAMP_W'(8);
    localparam logic [SAMP_W-1:0] SAMP_DECIDE = SAMP_W'(9);
    localparam logic [SAMP_W-1:0] SAMP_LAST   = SAMP_W'(15);
    localparam logic [BIDX_W-1:0] BIT_LAST    = BIDX_W'(7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              r_state;
    logic [SYNC_N-1:0]   r_sync;
    logic                r_prev;
    logic [TICK_W-1:0]   r_div;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [SAMP_W-1:0]   r_samp_cnt;
    logic [BIDX_W-1:0]   r_bit_idx;
    logic                r_s7;
    logic                r_s8;
    logic [7:0]          r_shift;

    logic                w_rx;
    logic                w_fall;
    logic                w_tick;
    logic                w_decide;
    logic                w_bit_end;
    logic                w_vote;

    // Baud select to tick divider; unused codes fall back to 9600.
    function automatic logic [TICK_W-1:0] div_for(input logic [2:0] sel);
        logic [TICK_W-1:0] d;
        case (sel)
            3'b000:  d = DIV_9600;
            3'b001:  d = DIV_19200;
            3'b010:  d = DIV_38400;
            3'b011:  d = DIV_57600;
            3'b100:  d = DIV_115200;
            default: d = DIV_9600;
        endcase
        return d;
    endfunction

    assign w_rx      = r_sync[SYNC_N-1];
    assign w_fall    = r_prev & ~w_rx;
    assign w_tick    = (r_state != S_IDLE) && (r_tick_cnt == r_div);
    assign w_decide  = w_tick && (r_samp_cnt == SAMP_DECIDE);
    assign w_bit_end = w_tick && (r_samp_cnt == SAMP_LAST);
    assign w_vote    = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);

    // Synchronise the async line; preset to idle-high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_N-2:0], uart_rx};
            r_prev <= w_rx;
        end
    end

    // Oversample tick generator: free-runs only while a frame is in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if ((r_state == S_IDLE) || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // Capture the first two of the three centre samples; the third is the live synced value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s7 <= 1'b0;
            r_s8 <= 1'b0;
        end else begin
            if (w_tick && (r_samp_cnt == SAMP_FIRST)) begin
                r_s7 <= w_rx;
            end
            if (w_tick && (r_samp_cnt == SAMP_SECOND)) begin
                r_s8 <= w_rx;
            end
        end
    end

    // Frame FSM with its counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_div       <= DIV_9600;
            r_samp_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            data_byte   <= '0;
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
            rx_state    <= 1'b0;
        end else begin
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
            if (w_tick) begin
                r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_samp_cnt <= '0;
                    r_bit_idx  <= '0;
                    if (w_fall) begin
                        r_div    <= div_for(baud_set);
                        r_state  <= S_START;
                        rx_state <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_decide && w_vote) begin
                        // Line was high at the start-bit centre: a glitch, not a frame.
                        r_state  <= S_IDLE;
                        rx_state <= 1'b0;
                    end else if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                    end
                end

                S_DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_vote, r_shift[7:1]};
                    end
                    if (w_bit_end) begin
                        if (r_bit_idx == BIT_LAST) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + BIDX_W'(1);
                        end
                    end
                end

                S_STOP: begin
                    // Leave at the stop-bit centre to give margin for a following start bit.
                    if (w_decide) begin
                        r_state  <= S_IDLE;
                        rx_state <= 1'b0;
                        if (w_vote) begin
                            data_byte <= r_shift;
                            rx_done   <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    rx_state <= 1'b0;
                end
            endcase
        end
    end

endmodule
